// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, range check and port-select encoding for the data-memory arbiter
package dmem_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_WORDS = 64;

    localparam logic [ADDR_W-3:0] MEM_WORDS_IDX = MEM_WORDS[ADDR_W-3:0];

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_CPU  = 2'd1,
        PORT_DBG  = 2'd2
    } port_e;

    // Word index is the byte address with the two byte-lane bits dropped.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2] < MEM_WORDS_IDX;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating wait counter with clear priority and at-limit flag
module starve_counter #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_W = LIMIT[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT_W)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count == LIMIT_W);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter for the single-port data memory with starvation guard
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_err,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    logic  w_at_limit;
    logic  w_dbg_sel;
    logic  w_cpu_sel;
    logic  w_dbg_ok;
    logic  w_cpu_ok;
    port_e w_port;

    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_dbg_err;

    assign w_dbg_sel = i_dbg_req && (!i_cpu_req || w_at_limit);
    assign w_cpu_sel = i_cpu_req && !w_dbg_sel;
    assign w_dbg_ok  = addr_in_range(i_dbg_addr) && (i_dbg_addr[1:0] == 2'b00);
    assign w_cpu_ok  = addr_in_range(i_cpu_addr);
    assign w_port    = w_dbg_sel ? PORT_DBG : (w_cpu_sel ? PORT_CPU : PORT_NONE);

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .WIDTH (4)
    ) u_starve (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_dbg_sel || !i_dbg_req),
        .i_inc      (i_dbg_req && !w_dbg_sel),
        .o_at_limit (w_at_limit)
    );

    // Rejected DBG accesses still drive the address but never strobe the memory;
    // out-of-range CPU accesses only lose the write strobe.
    always_comb begin
        o_mem_write = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (w_port)
            PORT_DBG: begin
                o_mem_addr  = i_dbg_addr;
                o_mem_wdata = i_dbg_wdata;
                o_mem_write = i_dbg_we && w_dbg_ok;
                o_mem_read  = !i_dbg_we && w_dbg_ok;
            end
            PORT_CPU: begin
                o_mem_addr  = i_cpu_addr;
                o_mem_wdata = i_cpu_wdata;
                o_mem_write = i_cpu_we && w_cpu_ok;
                o_mem_read  = !i_cpu_we;
            end
            default: ;
        endcase
    end

    assign o_cpu_rdata = (w_cpu_sel && !i_cpu_we && w_cpu_ok) ? i_mem_rdata : '0;
    assign o_cpu_stall = i_cpu_req && w_dbg_sel;
    assign o_dbg_gnt   = w_dbg_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
            r_dbg_err    <= 1'b0;
        end else begin
            r_dbg_rvalid <= w_dbg_sel && w_dbg_ok && !i_dbg_we;
            r_dbg_err    <= w_dbg_sel && !w_dbg_ok;
            if (w_dbg_sel && w_dbg_ok && !i_dbg_we) begin
                r_dbg_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_dbg_rvalid = r_dbg_rvalid;
    assign o_dbg_rdata  = r_dbg_rdata;
    assign o_dbg_err    = r_dbg_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a word-array reference model
module tb_dmem_arbiter;

    localparam int LIMIT = 4;
    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata), .o_dbg_err(dbg_err),
        .o_mem_write(mem_write), .o_mem_read(mem_read), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Data memory attached to the arbiter: synchronous write, combinational read
    logic [31:0] mem [WORDS];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

    typedef struct {
        int          cyc;
        logic [31:0] cpu_rdata;
        logic        cpu_stall, dbg_gnt, mem_write, mem_read;
        logic [31:0] mem_addr;
    } comb_t;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } resp_t;

    comb_t       exp_comb[$];
    resp_t       exp_resp[$];
    logic [31:0] ref_mem [WORDS];
    int          wait_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd,
                         input bit in_rst, output bit granted);
        comb_t e;
        resp_t r;
        bit    dbg_wins, cpu_served, dok, cok;
        int    dword, cword;
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) begin
            rst_n = 1'b0;
            exp_resp.delete();
            wait_cnt = 0;
        end else begin
            rst_n = 1'b1;
        end
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;

        dword      = int'(daddr >> 2);
        cword      = int'(caddr >> 2);
        dok        = (daddr < 32'(WORDS * 4)) && (daddr % 4 == 0);
        cok        = caddr < 32'(WORDS * 4);
        dbg_wins   = dreq && (!creq || wait_cnt == LIMIT);
        cpu_served = creq && !dbg_wins;
        granted    = dbg_wins;

        e.cyc       = cyc;
        e.cpu_stall = creq && dbg_wins;
        e.dbg_gnt   = dbg_wins;
        e.cpu_rdata = (cpu_served && !cwe && cok) ? ref_mem[cword] : 32'd0;
        e.mem_write = (dbg_wins && dwe && dok) || (cpu_served && cwe && cok);
        e.mem_read  = (dbg_wins && !dwe && dok) || (cpu_served && !cwe);
        e.mem_addr  = dbg_wins ? daddr : (cpu_served ? caddr : 32'd0);
        exp_comb.push_back(e);

        if (!in_rst && dbg_wins) begin
            r.due  = cyc + 1;
            r.err  = !dok;
            r.data = dok ? ref_mem[dword] : 32'd0;
            if (!dok || !dwe) exp_resp.push_back(r);
        end
        if (!in_rst) begin
            if (dbg_wins || !dreq) wait_cnt = 0;
            else if (wait_cnt < LIMIT) wait_cnt++;
        end
        if (dbg_wins && dwe && dok) ref_mem[dword] = dwd;
        if (cpu_served && cwe && cok) ref_mem[cword] = cwd;
    endtask

    always @(negedge clk) begin : monitor
        comb_t e;
        resp_t r;
        if (exp_comb.size() > 0) begin
            e = exp_comb.pop_front();
            checks++;
            if (cpu_rdata !== e.cpu_rdata || cpu_stall !== e.cpu_stall || dbg_gnt !== e.dbg_gnt ||
                mem_write !== e.mem_write || mem_read !== e.mem_read || mem_addr !== e.mem_addr) begin
                failures++;
                $display("FAIL comb cyc=%0d got rdata=%h stall=%b gnt=%b we=%b re=%b addr=%h want rdata=%h stall=%b gnt=%b we=%b re=%b addr=%h",
                         e.cyc, cpu_rdata, cpu_stall, dbg_gnt, mem_write, mem_read, mem_addr,
                         e.cpu_rdata, e.cpu_stall, e.dbg_gnt, e.mem_write, e.mem_read, e.mem_addr);
            end
        end
        if (dbg_rvalid || dbg_err) begin
            checks++;
            if (exp_resp.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected cyc=%0d got rvalid=%b err=%b want none", cyc, dbg_rvalid, dbg_err);
            end else begin
                r = exp_resp.pop_front();
                if (r.due != cyc || dbg_err !== r.err || dbg_rvalid !== !r.err ||
                    (!r.err && dbg_rdata !== r.data)) begin
                    failures++;
                    $display("FAIL resp cyc=%0d got rvalid=%b err=%b data=%h want due=%0d err=%b data=%h",
                             cyc, dbg_rvalid, dbg_err, dbg_rdata, r.due, r.err, r.data);
                end
            end
        end else if (exp_resp.size() > 0 && exp_resp[0].due <= cyc) begin
            r = exp_resp.pop_front();
            checks++;
            failures++;
            $display("FAIL resp_missing cyc=%0d got none want err=%b data=%h", cyc, r.err, r.data);
        end
    end

    function automatic logic [31:0] pick_addr(input bit allow_mis);
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel <= 4) return 32'($urandom_range(0, 15)) << 2;
        if (sel == 5) return (32'($urandom_range(0, 63)) << 2) | (allow_mis ? 32'($urandom_range(1, 3)) : 32'd0);
        if (sel == 6) return 32'($urandom_range(64, 80)) << 2;
        return 32'd252;
    endfunction

    initial begin : stimulus
        bit          g;
        bit          d_pend;
        logic        d_we, d_req;
        logic [31:0] d_addr, d_wd;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, g);

        drive(1, 1, 32'h8, 32'h5, 0, 0, 0, 0, 0, g);
        drive(1, 0, 32'h8, 32'h0, 0, 0, 0, 0, 0, g);
        drive(0, 0, 0, 0, 1, 1, 32'h10, 32'hAA, 0, g);
        drive(0, 0, 0, 0, 1, 0, 32'h10, 32'h0, 0, g);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        repeat (6) drive(1, 0, 32'h8, 0, 1, 0, 32'h10, 0, 0, g);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        drive(0, 0, 0, 0, 1, 0, 32'h100, 0, 0, g);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        drive(0, 0, 0, 0, 1, 0, 32'h6, 0, 0, g);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        drive(1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, g);
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, g);

        drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, g);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, g);
        repeat (6) drive(1, 0, 32'h8, 0, 1, 0, 32'h10, 0, 0, g);

        d_pend = 0; d_we = 0; d_addr = 0; d_wd = 0;
        for (int n = 0; n < 600; n++) begin
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_we   = 1'($urandom_range(0, 1));
                d_addr = pick_addr(1);
                d_wd   = $urandom;
            end
            d_req = d_pend;
            if (d_pend && $urandom_range(0, 19) == 0) begin
                d_req  = 0;
                d_pend = 0;
            end
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick_addr(1), $urandom,
                  d_req, d_we, d_addr, d_wd, 0, g);
            if (g) d_pend = 0;
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_resp.size() != 0) begin
            failures++;
            $display("FAIL resp_drain got %0d pending want 0", exp_resp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
